fetch_buf_reader: RTL and testbench

- Decode-side consumer of the two-half fetch buffer that the fetch FSM fills.
- Stores the 16-byte halves loaded by fetch, keeps the decode read pointer, and presents a 16-byte instruction window plus a valid-byte count to decode.
- Retires whole halves as decode consumes past them.
- Returns the pointer half (de_p) and half-valid status back to fetch so it can decide which half to refill.

---
 rtl/fetch_buf_reader.sv | 190 +++++++++++++++++++
 tb/tb_fetch_buf_reader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buf_reader.sv
`default_nettype none
// ============================================================================
// Module      : fetch_buf_reader
// Description : Decode-side consumer of the two-half fetch buffer.
//               - Holds the two HALF_BYTES-wide halves written by the fetch FSM.
//               - Keeps the decode read pointer.
//               - Presents a WIN_BYTES-wide circular window and the count of
//                 contiguous valid bytes starting at the pointer.
//               - Retires a half once decode consumes past it, and reports
//                 the pointer half and per-half valid bits back to fetch.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   HALF_BYTES   bytes per buffer half (power of 2); buffer is 2*HALF_BYTES
//   WIN_BYTES    bytes presented to decode per cycle (<= HALF_BYTES)
// Ports
//   clk           clock
//   rst_n         asynchronous active-low reset
//   f_ld_buf_i    per-half load strobes (bit k loads half k)
//   f_line_i      fetched line, byte 0 in bits [7:0]
//   flush_i       redirect: invalidate both halves, reload pointer
//   flush_off_i   byte offset of the redirect target within the next line
//   de_take_i     decode consumes de_len_i bytes this cycle
//   de_len_i      number of bytes consumed (1..WIN_BYTES)
//   win_bytes_o   bytes ptr..ptr+WIN_BYTES-1, circular over the buffer
//   de_avail_o    contiguous valid bytes starting at ptr
//   de_p_o        half holding the read pointer (pointer MSB)
//   buf_vld_o     per-half valid bits
//   de_ovr_o      one-cycle pulse: consume exceeded de_avail_o, ignored
// Build option
//   FBUF_ZERO_MASK_EN  when defined, window bytes at or beyond de_avail_o
//                      are forced to 8'h00; otherwise raw storage is shown.
// ============================================================================
module fetch_buf_reader #(
    parameter int HALF_BYTES = 16,
    parameter int WIN_BYTES  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      f_ld_buf_i,
    input  logic [8*HALF_BYTES-1:0]         f_line_i,
    input  logic                            flush_i,
    input  logic [$clog2(HALF_BYTES)-1:0]   flush_off_i,
    input  logic                            de_take_i,
    input  logic [$clog2(WIN_BYTES):0]      de_len_i,
    output logic [8*WIN_BYTES-1:0]          win_bytes_o,
    output logic [$clog2(2*HALF_BYTES):0]   de_avail_o,
    output logic                            de_p_o,
    output logic [1:0]                      buf_vld_o,
    output logic                            de_ovr_o
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int c_OFF_W = $clog2(HALF_BYTES);        // offset within a half
    localparam int c_PTR_W = c_OFF_W + 1;               // pointer over both halves
    localparam int c_AVL_W = $clog2(2*HALF_BYTES) + 1;  // 0..2*HALF_BYTES
    localparam int c_LEN_W = $clog2(WIN_BYTES) + 1;     // 0..WIN_BYTES

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [8*HALF_BYTES-1:0] half_q [2];
    logic [c_PTR_W-1:0]      ptr_q,  ptr_d;
    logic [1:0]              vld_q,  vld_d;
    logic                    ovr_q,  ovr_d;

    // ------------------------------------------------------------------------
    // Combinational view of the registered state
    // ------------------------------------------------------------------------
    logic                    w_hi;
    logic [c_OFF_W-1:0]      w_lo;
    logic [c_AVL_W-1:0]      w_avail;
    logic [16*HALF_BYTES-1:0] w_flat;

    assign w_hi   = ptr_q[c_PTR_W-1];
    assign w_lo   = ptr_q[c_OFF_W-1:0];
    assign w_flat = {half_q[1], half_q[0]};

    // Contiguous run starting at ptr: rest of the current half, plus the
    // whole other half when it is also valid. The other half always follows
    // the current one in circular order, so validity alone is enough.
    always_comb begin
        w_avail = '0;
        if (vld_q[w_hi]) begin
            w_avail = c_AVL_W'(HALF_BYTES) - c_AVL_W'(w_lo);
            if (vld_q[~w_hi]) begin
                w_avail = w_avail + c_AVL_W'(HALF_BYTES);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Decode window: byte i comes from buffer byte (ptr + i) mod 2*HALF_BYTES;
    // the pointer-width add wraps naturally.
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < WIN_BYTES; gi++) begin : g_win
        logic [c_PTR_W-1:0] w_idx;
        assign w_idx = ptr_q + c_PTR_W'(gi);
`ifdef FBUF_ZERO_MASK_EN
        assign win_bytes_o[gi*8 +: 8] = (c_AVL_W'(gi) < w_avail)
                                        ? w_flat[{w_idx, 3'b000} +: 8]
                                        : 8'h00;
`else
        assign win_bytes_o[gi*8 +: 8] = w_flat[{w_idx, 3'b000} +: 8];
`endif
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic               w_len_nz;
    logic               w_fits;
    logic               w_consume;
    logic               w_over;
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic [1:0]         w_rel;

    assign w_len_nz  = (de_len_i != '0);
    assign w_fits    = (c_AVL_W'(de_len_i) <= w_avail);
    // A zero-length take is treated as a no-op: neither consume nor overflow.
    assign w_consume = de_take_i && w_len_nz && w_fits;
    assign w_over    = de_take_i && w_len_nz && !w_fits;
    assign w_ptr_nxt = ptr_q + c_PTR_W'(de_len_i);

    // Leaving a half (including landing exactly on the next half's first
    // byte) releases it. Only the half the pointer started in can be left,
    // since one consume never exceeds a half.
    always_comb begin
        w_rel = 2'b00;
        if (w_consume && (w_ptr_nxt[c_PTR_W-1] != w_hi)) begin
            w_rel[w_hi] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        vld_d = vld_q;
        ovr_d = 1'b0;
        if (flush_i) begin
            // Redirect wins over any load or consume in the same cycle.
            ptr_d = {1'b0, flush_off_i};
            vld_d = 2'b00;
        end else begin
            if (w_consume) begin
                ptr_d = w_ptr_nxt;
            end
            // Load after release so a same-cycle reload of the released half
            // leaves it valid.
            vld_d = (vld_q & ~w_rel) | f_ld_buf_i;
            ovr_d = w_over;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            vld_q <= 2'b00;
            ovr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            ovr_q <= ovr_d;
        end
    end

    for (genvar gh = 0; gh < 2; gh++) begin : g_half
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                half_q[gh] <= '0;
            end else if (!flush_i && f_ld_buf_i[gh]) begin
                half_q[gh] <= f_line_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign de_avail_o = w_avail;
    assign de_p_o     = ptr_q[c_PTR_W-1];
    assign buf_vld_o  = vld_q;
    assign de_ovr_o   = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_buf_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_buf_reader
// Description : Directed bench for fetch_buf_reader with hand-computed
//               expected values checked by immediate assertions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buf_reader;

    logic         clk;
    logic         rst_n;
    logic [1:0]   f_ld_buf;
    logic [127:0] f_line;
    logic         flush;
    logic [3:0]   flush_off;
    logic         de_take;
    logic [4:0]   de_len;
    logic [127:0] win_bytes;
    logic [5:0]   de_avail;
    logic         de_p;
    logic [1:0]   buf_vld;
    logic         de_ovr;

    int n_vec = 0;
    int n_err = 0;

    fetch_buf_reader #(.HALF_BYTES(16), .WIN_BYTES(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .f_ld_buf_i  (f_ld_buf),
        .f_line_i    (f_line),
        .flush_i     (flush),
        .flush_off_i (flush_off),
        .de_take_i   (de_take),
        .de_len_i    (de_len),
        .win_bytes_o (win_bytes),
        .de_avail_o  (de_avail),
        .de_p_o      (de_p),
        .buf_vld_o   (buf_vld),
        .de_ovr_o    (de_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line whose byte i is base+i.
    function automatic logic [127:0] seq(input logic [7:0] base);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = base + 8'(i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [127:0] exp_w;

    initial begin
        rst_n     = 1'b0;
        f_ld_buf  = 2'b00;
        f_line    = '0;
        flush     = 1'b0;
        flush_off = '0;
        de_take   = 1'b0;
        de_len    = '0;
        #12;
        // Reset state
        chk("rst_vld",   128'(buf_vld),  128'd0);
        chk("rst_avail", 128'(de_avail), 128'd0);
        chk("rst_win",   win_bytes,      128'd0);
        chk("rst_p",     128'(de_p),     128'd0);
        chk("rst_ovr",   128'(de_ovr),   128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Load half0 with 0x00..0x0F
        f_ld_buf = 2'b01; f_line = seq(8'h00);
        step();
        f_ld_buf = 2'b00;
        chk("ld0_vld",   128'(buf_vld),  128'h1);
        chk("ld0_avail", 128'(de_avail), 128'd16);
        chk("ld0_byte0", 128'(win_bytes[7:0]), 128'h00);
        chk("ld0_win",   win_bytes,      seq(8'h00));
        chk("ld0_p",     128'(de_p),     128'd0);

        // Flush to offset 5, refill both halves, consume 11 to the boundary
        flush = 1'b1; flush_off = 4'd5;
        step();
        flush = 1'b0;
        chk("fl5_vld",   128'(buf_vld),  128'h0);
        chk("fl5_avail", 128'(de_avail), 128'd0);
        f_ld_buf = 2'b01; f_line = seq(8'h00);
        step();
        f_ld_buf = 2'b10; f_line = seq(8'h10);
        step();
        f_ld_buf = 2'b00;
        chk("fl5_avail27", 128'(de_avail), 128'd27);
        chk("fl5_byte0",   128'(win_bytes[7:0]), 128'h05);
        chk("fl5_win",     win_bytes,      seq(8'h05));
        de_take = 1'b1; de_len = 5'd11;
        step();
        de_take = 1'b0;
        chk("c11_vld",   128'(buf_vld),  128'h2);
        chk("c11_p",     128'(de_p),     128'd1);
        chk("c11_avail", 128'(de_avail), 128'd16);
        chk("c11_win",   win_bytes,      seq(8'h10));

        // Reach ptr=14 with both halves valid
        f_ld_buf = 2'b01; f_line = seq(8'h20);
        step();
        f_ld_buf = 2'b00;
        chk("ld0b_avail", 128'(de_avail), 128'd32);
        de_take = 1'b1; de_len = 5'd14;
        step();
        chk("c14_avail", 128'(de_avail), 128'd18);
        chk("c14_vld",   128'(buf_vld),  128'h3);
        de_len = 5'd16;                          // 30 -> 14, wraps, leaves half1
        step();
        de_take = 1'b0;
        chk("wrap_vld",   128'(buf_vld),  128'h1);
        chk("wrap_avail", 128'(de_avail), 128'd2);
        chk("wrap_p",     128'(de_p),     128'd0);
        f_ld_buf = 2'b10; f_line = seq(8'h10);
        step();
        chk("p14_avail", 128'(de_avail), 128'd18);
        // Consume 6 (14 -> 20) releasing half0 while half0 is reloaded
        f_ld_buf = 2'b01; f_line = seq(8'h40);
        de_take = 1'b1; de_len = 5'd6;
        step();
        f_ld_buf = 2'b00; de_take = 1'b0;
        chk("ldwin_vld",   128'(buf_vld),  128'h3);
        chk("ldwin_avail", 128'(de_avail), 128'd28);
        chk("ldwin_p",     128'(de_p),     128'd1);
        for (int i = 0; i < 16; i++)
            exp_w[i*8 +: 8] = (i < 12) ? 8'(8'h14 + i) : 8'(8'h40 + i - 12);
        chk("ldwin_win", win_bytes, exp_w);

        // Walk down to de_avail=3: 20 -> 4 (release half1), 4 -> 13
        de_take = 1'b1; de_len = 5'd16;
        step();
        chk("c16_vld",   128'(buf_vld),  128'h1);
        chk("c16_avail", 128'(de_avail), 128'd12);
        de_len = 5'd9;
        step();
        chk("c9_avail", 128'(de_avail), 128'd3);
        de_len = 5'd0;                           // zero-length take: no-op
        step();
        chk("len0_avail", 128'(de_avail), 128'd3);
        chk("len0_ovr",   128'(de_ovr),   128'd0);
        de_len = 5'd7;                           // overflow
        step();
        de_take = 1'b0;
        chk("ovr_pulse", 128'(de_ovr),   128'd1);
        chk("ovr_avail", 128'(de_avail), 128'd3);
        chk("ovr_vld",   128'(buf_vld),  128'h1);
        step();
        chk("ovr_clear", 128'(de_ovr),   128'd0);
        chk("ovr_avail2", 128'(de_avail), 128'd3);
        // Exact fit lands on the boundary and releases half0
        de_take = 1'b1; de_len = 5'd3;
        step();
        de_take = 1'b0;
        chk("bnd_vld",   128'(buf_vld),  128'h0);
        chk("bnd_avail", 128'(de_avail), 128'd0);
        chk("bnd_p",     128'(de_p),     128'd1);

        // Flush with simultaneous load and consume
        f_ld_buf = 2'b10; f_line = seq(8'h10);
        step();
        chk("pre_fl_avail", 128'(de_avail), 128'd16);
        flush = 1'b1; flush_off = 4'd7;
        f_ld_buf = 2'b01; f_line = seq(8'hA0);
        de_take = 1'b1; de_len = 5'd4;
        step();
        flush = 1'b0; f_ld_buf = 2'b00; de_take = 1'b0;
        chk("flx_vld",   128'(buf_vld),  128'h0);
        chk("flx_avail", 128'(de_avail), 128'd0);
        chk("flx_p",     128'(de_p),     128'd0);
        chk("flx_ovr",   128'(de_ovr),   128'd0);

        // Refill from offset 7 and move to ptr=30 with only half1 valid
        f_ld_buf = 2'b01; f_line = seq(8'h00);
        step();
        f_ld_buf = 2'b10; f_line = seq(8'h10);
        step();
        f_ld_buf = 2'b00;
        chk("fl7_avail", 128'(de_avail), 128'd25);
        chk("fl7_win",   win_bytes,      seq(8'h07));
        de_take = 1'b1; de_len = 5'd9;
        step();
        chk("c9b_vld", 128'(buf_vld), 128'h2);
        de_len = 5'd14;
        step();
        de_take = 1'b0;
        chk("p30_avail", 128'(de_avail), 128'd2);
        chk("p30_p",     128'(de_p),     128'd1);
        for (int i = 0; i < 16; i++) begin
`ifdef FBUF_ZERO_MASK_EN
            exp_w[i*8 +: 8] = (i < 2) ? 8'(8'h1E + i) : 8'h00;
`else
            exp_w[i*8 +: 8] = (i < 2) ? 8'(8'h1E + i) : 8'(i - 2);
`endif
        end
        chk("p30_win", win_bytes, exp_w);
        // 30 + 2 wraps to 0 and releases half1
        de_take = 1'b1; de_len = 5'd2;
        step();
        de_take = 1'b0;
        chk("wrap0_vld",   128'(buf_vld),  128'h0);
        chk("wrap0_avail", 128'(de_avail), 128'd0);
        chk("wrap0_p",     128'(de_p),     128'd0);

        // Asynchronous reset mid-operation
        f_ld_buf = 2'b01; f_line = seq(8'h60);
        step();
        f_ld_buf = 2'b00;
        chk("pre_rst_avail", 128'(de_avail), 128'd16);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld",   128'(buf_vld),  128'h0);
        chk("arst_avail", 128'(de_avail), 128'd0);
        chk("arst_win",   win_bytes,      128'd0);
        #4;
        rst_n = 1'b1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
